index_merge_ctrl: RTL and testbench

INDEX_MERGE_CTRL -- requirements
Module: index_merge_ctrl

---
 rtl/index_merge_pkg.sv | 32 +++
 rtl/index_cmp.sv | 18 +
 rtl/index_merge_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_index_merge_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/index_merge_pkg.sv
// index_merge_pkg: shared types and constants for the index merge controller.
//   DATA_W    - width of a list entry
//   DEPTH     - number of entries per list RAM
//   IDX_W     - internal index width (one extra bit so DEPTH is representable)
//   state_t   - merge FSM state encoding
//   clamp_len - limits a requested length to DEPTH
package index_merge_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 5;

  localparam logic [IDX_W-1:0] DEPTH_IDX = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lengths above the RAM depth are treated as a full list so that an index
  // can never wrap back onto address 0 during a merge.
  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len);
    if (len > DEPTH_IDX) begin
      clamp_len = DEPTH_IDX;
    end else begin
      clamp_len = len;
    end
  endfunction

endpackage

// File: rtl/index_cmp.sv
// index_cmp: three-way unsigned comparison of the two RAM read words.
//   a, b        : operands (list 1 word, list 2 word)
//   lt / eq / gt: exactly one is high
module index_cmp
  import index_merge_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lt,
  output logic              eq,
  output logic              gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/index_merge_ctrl.sv
// index_merge_ctrl: loads two sorted lists into external RAMs, then walks
// both in lockstep and reports every value present in both (intersection).
//   clk, reset (sync, active-low)
//   start, len1, len2            : merge request and list lengths (0..16)
//   ld_valid, ld_sel, ld_data    : load strobe, target list, data (IDLE only)
//   wdata, wr_en1, wr_en2        : RAM write data / enables
//   cnt1, cnt2                   : RAM addresses (load pointer in IDLE,
//                                  merge index otherwise)
//   r1, r2                       : RAM read data, one cycle after address
//   m_valid, m_data              : match strobe / value
//   busy, done, match_cnt, ld_ovf: status
// Build option: INDEX_MERGE_DEDUP_EN suppresses a repeated equal value
// within one merge.
module index_merge_ctrl
  import index_merge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  len1,
  input  logic [IDX_W-1:0]  len2,
  input  logic              ld_valid,
  input  logic              ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_en1,
  output logic              wr_en2,
  output logic [3:0]        cnt1,
  output logic [3:0]        cnt2,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  match_cnt,
  output logic              ld_ovf
);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    lp1_r, lp1_s, lp2_r, lp2_s;
  logic [IDX_W-1:0]    idx1_r, idx1_s, idx2_r, idx2_s;
  logic [IDX_W-1:0]    len1_r, len1_s, len2_r, len2_s;
  logic                m_valid_r, m_valid_s;
  logic [DATA_W-1:0]   m_data_r, m_data_s;
  logic [IDX_W-1:0]    match_cnt_r, match_cnt_s;
  logic                ld_ovf_r, ld_ovf_s;
  logic                last_vld_r, last_vld_s;
  logic                we1_s, we2_s;
  logic                adv1_s, adv2_s;
  logic                dup_s;
  logic                lt_s, eq_s, gt_s;

  index_cmp u_cmp (
    .a  (r1),
    .b  (r2),
    .lt (lt_s),
    .eq (eq_s),
    .gt (gt_s)
  );

  // Repeated-value detection against the last value emitted in this merge.
  always_comb begin
`ifdef INDEX_MERGE_DEDUP_EN
    dup_s = last_vld_r && (r1 == m_data_r);
`else
    dup_s = 1'b0;
`endif
  end

  // Next-state, pointer, load and match logic.
  always_comb begin
    state_s     = state_r;
    lp1_s       = lp1_r;
    lp2_s       = lp2_r;
    idx1_s      = idx1_r;
    idx2_s      = idx2_r;
    len1_s      = len1_r;
    len2_s      = len2_r;
    m_valid_s   = 1'b0;
    m_data_s    = m_data_r;
    match_cnt_s = match_cnt_r;
    ld_ovf_s    = ld_ovf_r;
    last_vld_s  = last_vld_r;
    we1_s       = 1'b0;
    we2_s       = 1'b0;
    adv1_s      = 1'b0;
    adv2_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          // start has priority; a simultaneous load is dropped
          len1_s      = clamp_len(len1);
          len2_s      = clamp_len(len2);
          idx1_s      = 5'd0;
          idx2_s      = 5'd0;
          match_cnt_s = 5'd0;
          last_vld_s  = 1'b0;
          if ((len1 == 5'd0) || (len2 == 5'd0)) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else if (ld_valid) begin
          if (!ld_sel) begin
            if (lp1_r == DEPTH_IDX) begin
              ld_ovf_s = 1'b1;
            end else begin
              we1_s = 1'b1;
              lp1_s = lp1_r + 5'd1;
            end
          end else begin
            if (lp2_r == DEPTH_IDX) begin
              ld_ovf_s = 1'b1;
            end else begin
              we2_s = 1'b1;
              lp2_s = lp2_r + 5'd1;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = CMP;
      end
      CMP: begin
        if (eq_s) begin
          adv1_s = 1'b1;
          adv2_s = 1'b1;
          if (!dup_s) begin
            m_valid_s   = 1'b1;
            m_data_s    = r1;
            match_cnt_s = match_cnt_r + 5'd1;
            last_vld_s  = 1'b1;
          end else begin
            m_valid_s = 1'b0;
          end
        end else if (lt_s) begin
          adv1_s = 1'b1;
        end else begin
          adv2_s = gt_s;
        end
        idx1_s = idx1_r + {4'd0, adv1_s};
        idx2_s = idx2_r + {4'd0, adv2_s};
        // an index reaching its length ends the merge before it can address RAM
        if ((adv1_s && (idx1_s == len1_r)) || (adv2_s && (idx2_s == len2_r))) begin
          state_s = DONE;
        end else begin
          state_s = FETCH;
        end
      end
      DONE: begin
        lp1_s   = 5'd0;
        lp2_s   = 5'd0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      lp1_r       <= 5'd0;
      lp2_r       <= 5'd0;
      idx1_r      <= 5'd0;
      idx2_r      <= 5'd0;
      len1_r      <= 5'd0;
      len2_r      <= 5'd0;
      m_valid_r   <= 1'b0;
      m_data_r    <= 8'd0;
      match_cnt_r <= 5'd0;
      ld_ovf_r    <= 1'b0;
      last_vld_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      lp1_r       <= lp1_s;
      lp2_r       <= lp2_s;
      idx1_r      <= idx1_s;
      idx2_r      <= idx2_s;
      len1_r      <= len1_s;
      len2_r      <= len2_s;
      m_valid_r   <= m_valid_s;
      m_data_r    <= m_data_s;
      match_cnt_r <= match_cnt_s;
      ld_ovf_r    <= ld_ovf_s;
      last_vld_r  <= last_vld_s;
    end
  end

  // Writes must land in the same cycle as ld_valid, so the enables are
  // decoded directly; they are masked while reset is asserted.
  assign wdata     = ld_data;
  assign wr_en1    = we1_s && reset;
  assign wr_en2    = we2_s && reset;
  assign cnt1      = (state_r == IDLE) ? lp1_r[3:0] : idx1_r[3:0];
  assign cnt2      = (state_r == IDLE) ? lp2_r[3:0] : idx2_r[3:0];
  assign m_valid   = m_valid_r;
  assign m_data    = m_data_r;
  assign busy      = (state_r == FETCH) || (state_r == CMP);
  assign done      = (state_r == DONE);
  assign match_cnt = match_cnt_r;
  assign ld_ovf    = ld_ovf_r;

endmodule

// File: tb/tb_index_merge_ctrl.sv
// tb_index_merge_ctrl: directed scoreboard bench for index_merge_ctrl.
// Two behavioural 16x8 RAMs with one-cycle read latency sit on the ports.
module tb_index_merge_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] len1, len2;
  logic       ld_valid, ld_sel;
  logic [7:0] ld_data;
  logic [7:0] wdata;
  logic       wr_en1, wr_en2;
  logic [3:0] cnt1, cnt2;
  logic [7:0] r1, r2;
  logic       m_valid;
  logic [7:0] m_data;
  logic       busy, done;
  logic [4:0] match_cnt;
  logic       ld_ovf;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int wr1_cnt = 0;
  int wr2_cnt = 0;
  logic [7:0] exp_q [$];

  index_merge_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data),
    .wdata(wdata), .wr_en1(wr_en1), .wr_en2(wr_en2),
    .cnt1(cnt1), .cnt2(cnt2), .r1(r1), .r2(r2),
    .m_valid(m_valid), .m_data(m_data), .busy(busy), .done(done),
    .match_cnt(match_cnt), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  // RAM models: synchronous write, registered read.
  always @(posedge clk) begin
    if (wr_en1) mem1[cnt1] <= wdata;
    if (wr_en2) mem2[cnt2] <= wdata;
    r1 <= mem1[cnt1];
    r2 <= mem2[cnt2];
  end

  // Monitor: pops the scoreboard on every match and counts strobes.
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL m_valid_unexpected: got m_data=%0d, expected no match", m_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          fails++;
          $display("FAIL m_data: got %0d, expected %0d", m_data, e);
        end
      end
    end
    if (done)   done_cnt++;
    if (wr_en1) wr1_cnt++;
    if (wr_en2) wr2_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] a, input logic [4:0] b);
    len1  = a;
    len2  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for one done, then checks exactly one pulse and an empty queue.
  task automatic finish_merge(input string name, input int d0, input int exp_mc);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    tick();
    tick();
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_pending_matches"}, exp_q.size(), 0);
    check({name, "_match_cnt"}, match_cnt, exp_mc);
    exp_q.delete();
  endtask

  task automatic load_basic();
    load(1'b0, 8'd2); load(1'b0, 8'd5); load(1'b0, 8'd7); load(1'b0, 8'd9);
    load(1'b1, 8'd1); load(1'b1, 8'd5); load(1'b1, 8'd9); load(1'b1, 8'd12);
  endtask

  initial begin
    int d0, w0;
    reset = 1'b0; start = 1'b0; len1 = 5'd0; len2 = 5'd0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_data = 8'd0;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_ld_ovf", ld_ovf, 0);
    check("rst_cnt1", cnt1, 0);
    tick();

    // 17 loads into list 1: the last one overflows
    w0 = wr1_cnt;
    for (int i = 0; i < 17; i++) load(1'b0, 8'(i));
    tick();
    check("ovf_wr_en1_pulses", wr1_cnt - w0, 16);
    check("ovf_sticky", ld_ovf, 1);
    reset = 1'b0; tick(); reset = 1'b1; tick();
    check("ovf_cleared_by_reset", ld_ovf, 0);

    // basic intersection {2,5,7,9} x {1,5,9,12}
    load_basic();
    exp_q.push_back(8'd5); exp_q.push_back(8'd9);
    d0 = done_cnt;
    pulse_start(5'd4, 5'd4);
    @(negedge clk);
    check("basic_busy", busy, 1);
    finish_merge("basic", d0, 2);
    tick(); tick();
    check("basic_match_cnt_hold", match_cnt, 2);
    check("basic_idle_not_busy", busy, 0);

    // same merge with start and ld_valid hammered while busy
    load_basic();
    exp_q.push_back(8'd5); exp_q.push_back(8'd9);
    d0 = done_cnt;
    w0 = wr1_cnt + wr2_cnt;
    pulse_start(5'd4, 5'd4);
    start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'd99;
    tick(); tick(); tick(); tick();
    start = 1'b0; ld_valid = 1'b0;
    finish_merge("busy_ignore", d0, 2);
    check("busy_ignore_no_wr", wr1_cnt + wr2_cnt - w0, 0);

    // zero length: done the cycle after start, no match
    d0 = done_cnt;
    pulse_start(5'd0, 5'd4);
    @(negedge clk);
    check("zero_len_done_next", done, 1);
    check("zero_len_not_busy", busy, 0);
    finish_merge("zero_len", d0, 0);

    // start and load together: start wins, write dropped
    w0 = wr1_cnt;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'd7;
    d0 = done_cnt;
    pulse_start(5'd0, 5'd0);
    ld_valid = 1'b0;
    check("start_wins_no_wr", wr1_cnt - w0, 0);
    finish_merge("start_wins", d0, 0);

    // duplicates {3,3,4} x {3,3,4}
    load(1'b0, 8'd3); load(1'b0, 8'd3); load(1'b0, 8'd4);
    load(1'b1, 8'd3); load(1'b1, 8'd3); load(1'b1, 8'd4);
    exp_q.push_back(8'd3);
`ifndef INDEX_MERGE_DEDUP_EN
    exp_q.push_back(8'd3);
`endif
    exp_q.push_back(8'd4);
    d0 = done_cnt;
    pulse_start(5'd3, 5'd3);
`ifdef INDEX_MERGE_DEDUP_EN
    finish_merge("dup", d0, 2);
`else
    finish_merge("dup", d0, 3);
`endif

    // reset during CMP with a match pending
    load(1'b0, 8'd8); load(1'b1, 8'd8);
    d0 = done_cnt;
    pulse_start(5'd1, 5'd1);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_m_data", m_data, 0);
    check("abort_match_cnt", match_cnt, 0);
    check("abort_cnt2", cnt2, 0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
